// File: rtl/fp_norm_pkg.sv
// Shared constants and payload type for the floating-point normaliser datapath.
package fp_norm_pkg;

  localparam int MANT_W_SP = 24;
  localparam int EXP_W_SP  = 8;
  localparam int MANT_W_DP = 53;
  localparam int EXP_W_DP  = 11;
  localparam int SH_W_SP   = $clog2(MANT_W_SP + 1);
  localparam int SH_W_DP   = $clog2(MANT_W_DP + 1);

  // Stage payload at single-precision widths; parametrised users mirror this shape.
  typedef struct packed {
    logic                 sign;
    logic [EXP_W_SP-1:0]  exp;
    logic [MANT_W_SP-1:0] mant;
    logic [SH_W_SP-1:0]   lzc;
  } norm_payload_sp_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; lzc_o = MANT_W and zero_o = 1 for an all-zero input.
module fp_lzc #(
  parameter int MANT_W = 24,
  parameter int SH_W   = $clog2(MANT_W + 1)
) (
  input  logic [MANT_W-1:0] mant_i,
  output logic [SH_W-1:0]   lzc_o,
  output logic              zero_o
);

  logic [SH_W-1:0] lzc_s;
  logic            found_s;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lzc_s   = SH_W'(MANT_W);
    found_s = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      lzc_s   = (!found_s && mant_i[i]) ? SH_W'(MANT_W - 1 - i) : lzc_s;
      found_s = found_s || mant_i[i];
    end
  end

  assign lzc_o  = lzc_s;
  assign zero_o = ~found_s;

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage mantissa normaliser with valid/ready backpressure and underflow clamping.
// Define FP_NORM_UFLOW_CNT_EN to add the saturating uflow_cnt output.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_SP,
  parameter int EXP_W  = EXP_W_SP,
  parameter int SH_W   = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_uflow
`ifdef FP_NORM_UFLOW_CNT_EN
  ,
  output logic [15:0]       uflow_cnt
`endif
);

  localparam int CMP_W = max_w(EXP_W, SH_W);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [SH_W-1:0]   lzc;
  } payload_t;

  payload_t          s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_zero_q, s1_zero_d;
  logic              adv1_s, adv2_s;
  logic [SH_W-1:0]   lzc_s;
  logic              lzc_zero_s;

  logic              out_valid_q, out_valid_d;
  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic              out_zero_q, out_zero_d;
  logic              out_uflow_q, out_uflow_d;

  logic [CMP_W-1:0]  exp_c_s, lzc_c_s;
  logic [SH_W-1:0]   shift_s;
  logic [EXP_W-1:0]  n_exp_s;
  logic              n_zero_s, n_uflow_s;

  fp_lzc #(.MANT_W(MANT_W), .SH_W(SH_W)) u_lzc (
    .mant_i (in_mant),
    .lzc_o  (lzc_s),
    .zero_o (lzc_zero_s)
  );

  // Ready is derived from stage occupancy only, never from in_valid.
  assign adv2_s   = !out_valid_q || out_ready;
  assign adv1_s   = !s1_valid_q || adv2_s;
  assign in_ready = adv1_s;

  // Stage 1 next state: capture the input beat and its leading-zero count.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_zero_d  = s1_zero_q;
    if (adv1_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign = in_sign;
        s1_d.exp  = in_exp;
        s1_d.mant = in_mant;
        s1_d.lzc  = lzc_s;
        s1_zero_d = lzc_zero_s;
      end else begin
        s1_d      = s1_q;
        s1_zero_d = s1_zero_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Shift amount and exponent adjust; the clamp case stops at exponent 1 (stored as 0).
  always_comb begin
    exp_c_s   = CMP_W'(s1_q.exp);
    lzc_c_s   = CMP_W'(s1_q.lzc);
    shift_s   = '0;
    n_exp_s   = '0;
    n_zero_s  = 1'b0;
    n_uflow_s = 1'b0;
    if (s1_zero_q) begin
      n_zero_s = 1'b1;
    end else if (exp_c_s > lzc_c_s) begin
      shift_s = s1_q.lzc;
      n_exp_s = EXP_W'(exp_c_s - lzc_c_s);
    end else if (s1_q.exp != '0) begin
      shift_s   = SH_W'(exp_c_s - CMP_W'(1'b1));
      n_uflow_s = 1'b1;
    end else begin
      n_uflow_s = ~s1_q.mant[MANT_W-1];
    end
  end

  // Stage 2 next state: load results when the output slot is free or being drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_mant_d  = out_mant_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    if (adv2_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d  = s1_q.sign;
        out_exp_d   = n_exp_s;
        out_mant_d  = s1_q.mant << shift_s;
        out_zero_d  = n_zero_s;
        out_uflow_d = n_uflow_s;
      end else begin
        out_mant_d  = out_mant_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

`ifdef FP_NORM_UFLOW_CNT_EN
  logic [15:0] uflow_cnt_q, uflow_cnt_d;

  // Saturating count of delivered underflow results.
  always_comb begin
    uflow_cnt_d = uflow_cnt_q;
    if (out_valid_q && out_ready && out_uflow_q && (uflow_cnt_q != 16'hFFFF)) begin
      uflow_cnt_d = uflow_cnt_q + 16'd1;
    end else begin
      uflow_cnt_d = uflow_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt_q <= 16'd0;
    end else begin
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign uflow_cnt = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe (MANT_W=24, EXP_W=8) with a spec-level reference model.
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [23:0] in_mant = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_zero;
  logic        out_uflow;
`ifdef FP_NORM_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  fp_normalize_pipe #(.MANT_W(24), .EXP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
`ifdef FP_NORM_UFLOW_CNT_EN
    ,
    .uflow_cnt (uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        zero;
    logic        uflow;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_ucnt = 0;
  bit   lat_chk = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: count leading zeros, then apply zero / normal / clamp / denormal rules.
  function automatic exp_t ref_model(input logic s, input logic [7:0] e, input logic [23:0] m);
    exp_t r;
    int   lz = 24;
    int   sh = 0;
    logic [23:0] mm;
    for (int i = 0; i < 24; i++) begin
      if (lz == 24 && m[23 - i]) lz = i;
    end
    r.sign = s; r.zero = 1'b0; r.uflow = 1'b0; r.exp = 8'd0; r.acc_cyc = 0;
    if (m == 24'd0) begin
      r.zero = 1'b1;
    end else if (int'(e) > lz) begin
      sh = lz; r.exp = 8'(int'(e) - lz);
    end else if (e != 8'd0) begin
      sh = int'(e) - 1; r.uflow = 1'b1;
    end else begin
      r.uflow = ~m[23];
    end
    mm = m << sh;
    r.mant = mm;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every delivered result against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got mant %0h with empty scoreboard", out_mant);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_sign",  64'(out_sign),  64'(mon_e.sign));
        check("out_exp",   64'(out_exp),   64'(mon_e.exp));
        check("out_mant",  64'(out_mant),  64'(mon_e.mant));
        check("out_zero",  64'(out_zero),  64'(mon_e.zero));
        check("out_uflow", 64'(out_uflow), 64'(mon_e.uflow));
        if (lat_chk) check("latency", 64'(cyc - mon_e.acc_cyc), 64'd2);
`ifdef FP_NORM_UFLOW_CNT_EN
        check("uflow_cnt", 64'(uflow_cnt), 64'(model_ucnt));
        if (out_uflow && model_ucnt < 65535) model_ucnt++;
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m);
    exp_t r;
    bit   acc = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        r = ref_model(s, e, m);
        r.acc_cyc = cyc;
        sb_q.push_back(r);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [7:0]  snap_exp;
  logic [23:0] snap_mant;
  logic        snap_sign, snap_zero, snap_uflow;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_exp",   64'(out_exp),   64'd0);
    check("rst_out_mant",  64'(out_mant),  64'd0);
    check("rst_out_flags", 64'({out_sign, out_zero, out_uflow}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed cases and boundaries, no backpressure.
    lat_chk = 1'b1;
    send(1'b0, 8'd100, 24'h800000);
    send(1'b1, 8'd100, 24'h000001);
    send(1'b0, 8'd5,   24'h000100);
    send(1'b0, 8'd50,  24'h000000);
    send(1'b0, 8'd0,   24'h400000);
    send(1'b0, 8'd16,  24'h000100);
    send(1'b1, 8'd15,  24'h000100);
    send(1'b1, 8'd255, 24'hFFFFFF);
    send(1'b0, 8'd0,   24'h800000);
    send(1'b0, 8'd1,   24'h000001);
    send(1'b1, 8'd24,  24'h000001);
    drain();
    lat_chk = 1'b0;

    // Backpressure: four back-to-back beats, stall the first result for four cycles.
    fork
      begin
        send(1'b0, 8'd90, 24'h000F00);
        send(1'b1, 8'd3,  24'h000010);
        send(1'b0, 8'd0,  24'h000000);
        send(1'b1, 8'd40, 24'h0000A5);
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        snap_exp = out_exp; snap_mant = out_mant; snap_sign = out_sign;
        snap_zero = out_zero; snap_uflow = out_uflow;
        check("bp_first_valid", 64'(out_valid), 64'd1);
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_data", 64'({snap_sign, snap_exp, snap_mant, snap_zero, snap_uflow}),
                64'({out_sign, out_exp, out_mant, out_zero, out_uflow}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [23:0] m;
      logic [7:0]  e;
      m = 24'($urandom) >> $urandom_range(0, 24);
      e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      send(1'($urandom), e, m);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight: they must be discarded.
    out_ready = 1'b0;
    send(1'b0, 8'd70, 24'h00ABCD);
    send(1'b1, 8'd71, 24'h000123);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    sb_q.delete();
    model_ucnt = 0;
    @(posedge clk); #1;
    check("in_reset_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(1'b0, 8'd100, 24'h000001);
    send(1'b0, 8'd4,   24'h000200);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("final_no_extra", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Pipelined, parametrised normaliser for the floating-point datapath. Replaces single-cycle combinational left-shift normalisation.
- Counts leading zeros of a raw mantissa, left-shifts it so the MSB is 1, and decrements the exponent to match.
- Handles zero, denormal/underflow clamping and valid/ready backpressure.
- Sits between the add/sub mantissa stage and the rounding/pack stage.

Parameters:
MANT_W, 24, mantissa width including hidden bit (24 = single, 53 = double)
EXP_W, 8, biased exponent width
SH_W, $clog2(MANT_W+1), shift-amount / leading-zero-count width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  normaliser can accept a beat
in_sign  in  1  sign, passed through
in_exp  in  EXP_W  biased exponent before normalisation
in_mant  in  MANT_W  unnormalised mantissa
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sign  out  1  sign
out_exp  out  EXP_W  adjusted exponent
out_mant  out  MANT_W  normalised mantissa
out_zero  out  1  input mantissa was all-zero
out_uflow  out  1  shift clamped by exponent (denormal result)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_zero=0, out_uflow=0, internal stage valids=0. in_ready=1 one cycle after reset deasserts.
- Pipeline has 2 stages.
  - S1 registers sign, exp, mant and lzc = leading zero count of in_mant (0..MANT_W).
  - S2 registers the shifted result and the flags.
- Latency is 2 cycles from input handshake to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when valid and ready are both 1.
  - adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1.
  - No combinational path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, all out_* hold stable. No beat is dropped or duplicated, and order is preserved.
- S2 arithmetic, in priority order:
  - Zero: mant==0 → out_mant=0, out_exp=0, out_zero=1, out_uflow=0.
  - Normal: exp > lzc → shift=lzc, out_exp=exp-lzc, out_uflow=0.
  - Clamp: exp <= lzc and exp != 0 → shift=exp-1, out_exp=0, out_uflow=1.
  - Input already denormal: exp == 0 → shift=0, out_exp=0, out_uflow=1 if mant[MANT_W-1]==0, else 0.
- Shift rules: out_mant = mant << shift with zero fill; bits shifted out are lost. The shift is never more than MANT_W-1.
- Comparisons are unsigned, with lzc zero-extended to EXP_W. If SH_W > EXP_W, compare at max width.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: FP_NORM_UFLOW_CNT_EN.
- Defined:
  - Adds output port uflow_cnt [15:0].
  - Increments on each output handshake (out_valid && out_ready) with out_uflow=1.
  - Saturates at 16'hFFFF. Resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package fp_norm_pkg holds:
  - default MANT_W/EXP_W constants for single and double precision;
  - a typedef for the stage payload struct {sign, exp, mant, lzc}.
- Sub-module fp_lzc: combinational, parametrised by MANT_W. Outputs lzc [SH_W-1:0] and an all-zero flag. It is reused by the rounding stage.
- The shifter is inline in fp_normalize_pipe.

Test Plan (MANT_W=24, EXP_W=8):
- mant=0x800000, exp=100, out_ready=1 → 2 cycles later out_mant=0x800000, out_exp=100, zero=0, uflow=0.
- mant=0x000001, exp=100 → lzc=23, out_mant=0x800000, out_exp=77.
- mant=0x000100, exp=5 → lzc=15 clamps to shift 4, out_mant=0x001000, out_exp=0, uflow=1. With FP_NORM_UFLOW_CNT_EN, uflow_cnt=1 after the handshake.
- mant=0x000000, exp=50 → out_zero=1, out_mant=0, out_exp=0. Then mant=0x400000, exp=0 → shift 0, out_exp=0, uflow=1.
- Backpressure:
  - Stimulus: 4 back-to-back beats, with out_ready=0 from the cycle the first result becomes valid, held low for 4 cycles.
  - Response: in_ready=0 once 2 beats are held; outputs stay stable; after out_ready=1 all 4 results emerge in order with none lost.
- Reset mid-stream:
  - Stimulus: rst_n pulled low with 2 beats in flight.
  - Response: out_valid=0 immediately; after release, first new beat yields correct result at latency 2; the old beats never appear.
